// File: rtl/ctrl_pipe.sv
// Pipelined main control: ID decode, ID/EX, EX/MEM, MEM/WB control regs.
// Define CTRL_ADDI_EN to decode addi (6'b001000); otherwise it is illegal.
module ctrl_pipe #(
  parameter int OP_W = 6,
  parameter int RS_W = 5,
  parameter logic [OP_W-1:0] R_OP   = 6'b000000,
  parameter logic [OP_W-1:0] LW_OP  = 6'b100011,
  parameter logic [OP_W-1:0] SW_OP  = 6'b101011,
  parameter logic [OP_W-1:0] BEQ_OP = 6'b000100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] op_i,
  input  logic            valid_i,
  input  logic [RS_W-1:0] rs_i,
  input  logic [RS_W-1:0] rt_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic [3:0]      idex_ex_o,
  output logic [RS_W-1:0] idex_rt_o,
  output logic [2:0]      exmem_m_o,
  output logic            exmem_regwrite_o,
  output logic [1:0]      memwb_wb_o,
  output logic            illegal_o
);

`ifdef CTRL_ADDI_EN
  localparam logic [OP_W-1:0] ADDI_OP = OP_W'(6'b001000);
`endif

  logic [1:0]      dec_wb;
  logic [2:0]      dec_m;
  logic [3:0]      dec_ex;
  logic            dec_ill;

  logic [1:0]      idex_wb_q, idex_wb_d;
  logic [2:0]      idex_m_q, idex_m_d;
  logic [3:0]      idex_ex_q, idex_ex_d;
  logic [RS_W-1:0] idex_rt_q, idex_rt_d;
  logic            idex_ill_q, idex_ill_d;
  logic [1:0]      exmem_wb_q;
  logic [2:0]      exmem_m_q;
  logic [1:0]      memwb_wb_q;
  logic            bubble;

  always_comb begin
    dec_wb  = 2'b00;
    dec_m   = 3'b000;
    dec_ex  = 4'b0000;
    dec_ill = 1'b1;
    unique case (1'b1)
      (op_i == R_OP): begin
        dec_wb  = 2'b10;
        dec_ex  = 4'b1100;
        dec_ill = 1'b0;
      end
      (op_i == LW_OP): begin
        dec_wb  = 2'b11;
        dec_m   = 3'b010;
        dec_ex  = 4'b0001;
        dec_ill = 1'b0;
      end
      (op_i == SW_OP): begin
        dec_m   = 3'b001;
        dec_ex  = 4'b0001;
        dec_ill = 1'b0;
      end
      (op_i == BEQ_OP): begin
        dec_m   = 3'b100;
        dec_ex  = 4'b0010;
        dec_ill = 1'b0;
      end
`ifdef CTRL_ADDI_EN
      (op_i == ADDI_OP): begin
        dec_wb  = 2'b10;
        dec_ex  = 4'b0001;
        dec_ill = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  // r0 is never a real dependency, so a load to r0 never stalls
  assign stall_o = valid_i & idex_m_q[1]
                 & (idex_rt_q != '0)
                 & ((idex_rt_q == rs_i) | (idex_rt_q == rt_i));

  assign bubble = flush_i | stall_o | ~valid_i;

  always_comb begin
    idex_wb_d  = dec_wb;
    idex_m_d   = dec_m;
    idex_ex_d  = dec_ex;
    idex_rt_d  = rt_i;
    idex_ill_d = dec_ill;
    if (bubble) begin
      idex_wb_d  = '0;
      idex_m_d   = '0;
      idex_ex_d  = '0;
      idex_rt_d  = '0;
      idex_ill_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idex_wb_q  <= '0;
      idex_m_q   <= '0;
      idex_ex_q  <= '0;
      idex_rt_q  <= '0;
      idex_ill_q <= 1'b0;
      exmem_wb_q <= '0;
      exmem_m_q  <= '0;
      memwb_wb_q <= '0;
    end else begin
      idex_wb_q  <= idex_wb_d;
      idex_m_q   <= idex_m_d;
      idex_ex_q  <= idex_ex_d;
      idex_rt_q  <= idex_rt_d;
      idex_ill_q <= idex_ill_d;
      exmem_wb_q <= idex_wb_q;
      exmem_m_q  <= idex_m_q;
      memwb_wb_q <= exmem_wb_q;
    end
  end

  assign idex_ex_o        = idex_ex_q;
  assign idex_rt_o        = idex_rt_q;
  assign exmem_m_o        = exmem_m_q;
  assign exmem_regwrite_o = exmem_wb_q[1];
  assign memwb_wb_o       = memwb_wb_q;
  assign illegal_o        = idex_ill_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboarded bench for ctrl_pipe: directed cases plus random traffic
// against a per-instruction reference model of the control pipeline.
module tb_ctrl_pipe;

  localparam logic [5:0] R_OP   = 6'b000000;
  localparam logic [5:0] LW_OP  = 6'b100011;
  localparam logic [5:0] SW_OP  = 6'b101011;
  localparam logic [5:0] BEQ_OP = 6'b000100;
  localparam logic [5:0] ADI_OP = 6'b001000;
  localparam logic [5:0] BAD_OP = 6'b111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op_i;
  logic       valid_i;
  logic [4:0] rs_i;
  logic [4:0] rt_i;
  logic       flush_i;
  logic       stall_o;
  logic [3:0] idex_ex_o;
  logic [4:0] idex_rt_o;
  logic [2:0] exmem_m_o;
  logic       exmem_regwrite_o;
  logic [1:0] memwb_wb_o;
  logic       illegal_o;

  ctrl_pipe dut (
    .clk(clk), .rst_n(rst_n), .op_i(op_i), .valid_i(valid_i),
    .rs_i(rs_i), .rt_i(rt_i), .flush_i(flush_i), .stall_o(stall_o),
    .idex_ex_o(idex_ex_o), .idex_rt_o(idex_rt_o),
    .exmem_m_o(exmem_m_o), .exmem_regwrite_o(exmem_regwrite_o),
    .memwb_wb_o(memwb_wb_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] wb;
    logic [2:0] m;
    logic [3:0] ex;
    logic [4:0] rt;
    logic       ill;
  } ent_t;

  typedef struct packed {
    logic [3:0] ex;
    logic [4:0] rt;
    logic [2:0] m;
    logic       rw;
    logic [1:0] wb;
    logic       ill;
    logic       stall;
  } exp_t;

  exp_t sbq[$];
  ent_t p0, p1, p2;
  int   total = 0;
  int   bad = 0;
  logic last_stall;

  function automatic ent_t decode(input logic [5:0] op, input logic [4:0] rt);
    ent_t e;
    e = '0;
    e.rt = rt;
    if (op == R_OP) begin
      e.wb = 2'b10; e.ex = 4'b1100;
    end else if (op == LW_OP) begin
      e.wb = 2'b11; e.m = 3'b010; e.ex = 4'b0001;
    end else if (op == SW_OP) begin
      e.m = 3'b001; e.ex = 4'b0001;
    end else if (op == BEQ_OP) begin
      e.m = 3'b100; e.ex = 4'b0010;
`ifdef CTRL_ADDI_EN
    end else if (op == ADI_OP) begin
      e.wb = 2'b10; e.ex = 4'b0001;
`endif
    end else begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  task automatic step(input logic r, input logic v, input logic f,
                      input logic [5:0] op, input logic [4:0] rs,
                      input logic [4:0] rt);
    exp_t x;
    logic st;
    rst_n = r; valid_i = v; flush_i = f;
    op_i = op; rs_i = rs; rt_i = rt;
    st = v && p0.m == 3'b010 && p0.rt != 0 && (p0.rt == rs || p0.rt == rt);
    x.ex = p0.ex; x.rt = p0.rt; x.ill = p0.ill;
    x.m = p1.m; x.rw = p1.wb[1];
    x.wb = p2.wb;
    x.stall = st;
    sbq.push_back(x);
    last_stall = st && !f;
    @(posedge clk);
    if (!r) begin
      p0 = '0; p1 = '0; p2 = '0;
    end else begin
      p2 = p1;
      p1 = p0;
      p0 = (f || st || !v) ? ent_t'('0) : decode(op, rt);
    end
    #1;
  endtask

  task automatic chk(input string n, input logic [7:0] a,
                     input logic [7:0] b);
    total++;
    if (a !== b) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, a, b, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("stall", 8'(stall_o), 8'(e.stall));
      chk("idex_ex", 8'(idex_ex_o), 8'(e.ex));
      chk("idex_rt", 8'(idex_rt_o), 8'(e.rt));
      chk("illegal", 8'(illegal_o), 8'(e.ill));
      chk("exmem_m", 8'(exmem_m_o), 8'(e.m));
      chk("exmem_rw", 8'(exmem_regwrite_o), 8'(e.rw));
      chk("memwb_wb", 8'(memwb_wb_o), 8'(e.wb));
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, R_OP, 0, 0);
  endtask

  initial begin
    logic [5:0] op;
    logic [4:0] rs, rt;
    logic v, f, r;
    p0 = '0; p1 = '0; p2 = '0;
    last_stall = 1'b0;
    rst_n = 0; valid_i = 1; flush_i = 0;
    op_i = LW_OP; rs_i = 3; rt_i = 3;
    @(posedge clk); #1;
    step(0, 1, 0, LW_OP, 3, 3);
    step(0, 1, 0, R_OP, 3, 3);
    // cold lw through all three stages
    step(1, 1, 0, LW_OP, 1, 2);
    idle(3);
    // load-use, add held in ID across the stall
    step(1, 1, 0, LW_OP, 1, 5);
    step(1, 1, 0, R_OP, 5, 7);
    step(1, 1, 0, R_OP, 5, 7);
    idle(3);
    step(1, 1, 0, LW_OP, 1, 0);
    step(1, 1, 0, R_OP, 0, 0);
    idle(3);
    step(1, 1, 1, BEQ_OP, 2, 3);
    idle(2);
    // flush coinciding with a hazard
    step(1, 1, 0, LW_OP, 1, 6);
    step(1, 1, 1, R_OP, 6, 6);
    step(1, 1, 0, SW_OP, 6, 6);
    idle(3);
    step(1, 1, 0, BAD_OP, 1, 1);
    idle(2);
    step(1, 0, 0, BAD_OP, 1, 1);
    idle(2);
    step(1, 1, 0, ADI_OP, 1, 4);
    idle(3);
    // reset mid-stream drops in-flight control
    step(1, 1, 0, LW_OP, 1, 9);
    step(1, 1, 0, R_OP, 2, 3);
    step(0, 1, 0, R_OP, 9, 3);
    step(1, 1, 0, R_OP, 9, 3);
    idle(3);
    for (int i = 0; i < 400; i++) begin
      if (!(last_stall && $urandom_range(0, 9) < 7)) begin
        case ($urandom_range(0, 6))
          0: op = R_OP;
          1: op = LW_OP;
          2: op = LW_OP;
          3: op = SW_OP;
          4: op = BEQ_OP;
          5: op = ($urandom_range(0, 1) == 0) ? ADI_OP : BAD_OP;
          default: op = 6'($urandom);
        endcase
        rs = 5'($urandom_range(0, 5));
        rt = 5'($urandom_range(0, 5));
        v = ($urandom_range(0, 9) < 8);
      end else begin
        op = op_i; rs = rs_i; rt = rt_i; v = 1'b1;
      end
      f = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 49) != 0);
      step(r, v, f, op, rs, rt);
    end
    idle(2);
    repeat (2) @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d exp=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Pipelined main control unit for the 5-stage datapath. Decodes the ID-stage opcode into the WB/M/EX control groups and carries them through the ID/EX, EX/MEM and MEM/WB control registers. Detects load-use hazards, inserts bubbles on stall, flush or invalid slot, and flags illegal opcodes. It supersedes the purely combinational decoder; decode values for R/lw/sw/beq are unchanged.

## Interface
Parameters:
- OP_W, 6, opcode width
- RS_W, 5, register-specifier width
- R_OP, 6'b000000, R-type opcode
- LW_OP, 6'b100011, load-word opcode
- SW_OP, 6'b101011, store-word opcode
- BEQ_OP, 6'b000100, branch-equal opcode

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- op_i  in  OP_W  ID-stage opcode
- valid_i  in  1  ID slot holds a real instruction
- rs_i  in  RS_W  ID-stage rs
- rt_i  in  RS_W  ID-stage rt
- flush_i  in  1  discard the ID instruction (taken branch)
- stall_o  out  1  load-use hazard; hold PC and IF/ID (combinational)
- idex_ex_o  out  4  ID/EX EX group {RegDst, ALUOp[1:0], ALUSrc}
- idex_rt_o  out  RS_W  ID/EX rt (to forwarding/hazard logic)
- exmem_m_o  out  3  EX/MEM M group {Branch, MemRead, MemWrite}
- exmem_regwrite_o  out  1  EX/MEM RegWrite (forwarding)
- memwb_wb_o  out  2  MEM/WB WB group {RegWrite, MemtoReg}
- illegal_o  out  1  ID/EX holds an unrecognised opcode

## Operation
- Decode (combinational, ID), WB/M/EX: R_OP 10/000/1100; LW_OP 11/010/0001; SW_OP 00/001/0001; BEQ_OP 00/100/0010; any other opcode gives all zeros plus illegal=1. Full default assignment; no latches.
- ID/EX register: {wb, m, ex, rt, illegal}. EX/MEM: {wb, m}. MEM/WB: {wb}. EX/MEM and MEM/WB always advance and never freeze.
- Hazard: stall_o = valid_i & idex_MemRead & (idex_rt != 0) & (idex_rt == rs_i | idex_rt == rt_i).
- Bubble means ID/EX loads all zeros (wb, m, ex, rt, illegal = 0).
- ID/EX load priority: reset > flush_i > stall_o > !valid_i (each gives a bubble) > decoded values.
- illegal_o is only set for a valid, unflushed, unstalled instruction. It is high for exactly the one cycle that instruction sits in ID/EX.
- A stalled instruction stays in ID because upstream holds. It is re-evaluated next cycle; the bubble has cleared idex_MemRead, so at most one stall cycle per load-use pair.
- flush_i and stall_o in the same cycle: flush wins and a bubble is inserted. stall_o is still driven per its equation, and upstream gives flush priority.

## Timing
- Reset: when rst_n=0 at a rising edge, all stage registers clear. idex_ex_o=0, idex_rt_o=0, exmem_m_o=0, exmem_regwrite_o=0, memwb_wb_o=0, illegal_o=0. stall_o=0 because idex_MemRead=0.
- Latency from op_i at edge N:
  - idex_ex_o valid after edge N.
  - exmem_m_o valid after N+1.
  - memwb_wb_o valid after N+2.
- stall_o is combinational from valid_i/rs_i/rt_i and the ID/EX state, in the same cycle.
- Reset asserted mid-stream drops all in-flight control at that edge. The first post-reset instruction behaves as from cold.

## Configuration
- CTRL_ADDI_EN defined: adds opcode 6'b001000 (addi), decoded WB=10, M=000, EX=0001, illegal=0.
- CTRL_ADDI_EN undefined: 6'b001000 decodes as illegal (all zeros, illegal=1).

## Test plan
- Reset, then lw (op 100011, valid=1):
  - idex_ex_o=0001 after edge 1.
  - exmem_m_o=010 after edge 2.
  - memwb_wb_o=11 after edge 3.
  - all outputs 0 during reset.
- Load-use: lw rt=5, then add with rs=5:
  - stall_o=1 for one cycle; the next edge loads a bubble (idex_ex_o=0000).
  - with add held, idex_ex_o=1100 on the following edge; stall_o=0.
- Load with rt=0 followed by a reader of r0 -> stall_o stays 0.
- beq in ID with flush_i=1 -> idex_ex_o=0000 and exmem_m_o=000 one edge later. flush_i=1 with a hazard in the same cycle -> bubble, single cycle only.
- Opcode 6'b111111 valid -> illegal_o=1 for exactly one cycle, all control zeros. With valid_i=0 -> illegal_o stays 0.
- Opcode 6'b001000:
  - with CTRL_ADDI_EN -> idex_ex_o=0001, memwb_wb_o=10 two edges later.
  - without it -> illegal_o=1.
